// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types, defaults and width helpers for the FIFO write-port arbiter.
package fifo_write_arbiter_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int WIDTH_DEF     = 256;
  localparam int N_REQ_DEF     = 4;
  localparam int BURST_MAX_DEF = 4;
  localparam int GID_W_DEF     = clog2(N_REQ_DEF);
  localparam int BCNT_W_DEF    = clog2(BURST_MAX_DEF + 1);

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester-side handshakes and the simple_fifo write port, bundled for the arbiter.
interface fifo_write_arbiter_if
  import fifo_write_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N_REQ = N_REQ_DEF
) ();

  localparam int GID_W = clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_last;
  logic [N_REQ-1:0]       req_ready;
  logic                   fifo_we;
  logic [WIDTH-1:0]       fifo_din;
  logic                   fifo_full;
  logic                   grant_valid;
  logic [GID_W-1:0]       grant_id;

  modport master (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_we, fifo_din, grant_valid, grant_id
  );

  modport slave (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_we, fifo_din, grant_valid, grant_id
  );

endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Round-robin picker: first asserted request searching upward from last_ptr+1, wrapping at N.
module fifo_write_arbiter_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_ptr,
  output logic [W-1:0] winner,
  output logic         any
);

  logic [W-1:0] idx;

  // Walk from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    winner = last_ptr;
    idx    = '0;
    for (int k = N; k >= 1; k--) begin
      idx = W'((int'(last_ptr) + k) % N);
      if (req[idx]) winner = idx;
    end
  end

  assign any = |req;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-locked arbiter sharing one simple_fifo write port among N_REQ producers.
// Optional per-requester beat and stall counters: define FIFO_WRITE_ARBITER_STATS_EN.
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int N_REQ     = N_REQ_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  fifo_write_arbiter_if.master   bus
`ifdef FIFO_WRITE_ARBITER_STATS_EN
  ,
  output logic [N_REQ*32-1:0]    beat_count,
  output logic [31:0]            stall_count
`endif
);

  // state | meaning
  // IDLE  | no owner; arbitrate among valid requesters, no data moves
  // BURST | grant_id owns the write port until last or BURST_MAX beats
  localparam logic [0:0] ST_IDLE  = IDLE;
  localparam logic [0:0] ST_BURST = BURST;

  localparam int GID_W  = clog2(N_REQ);
  localparam int BCNT_W = clog2(BURST_MAX + 1);

  localparam logic [GID_W-1:0]  PTR_INIT  = GID_W'(N_REQ - 1);
  localparam logic [BCNT_W-1:0] BEAT_LAST = BCNT_W'(BURST_MAX - 1);

  logic [0:0]        state;
  logic [GID_W-1:0]  grant_id_q;
  logic [GID_W-1:0]  rr_ptr;
  logic [BCNT_W-1:0] beat_cnt;

  logic [GID_W-1:0]  winner;
  logic              any_req;
  logic              in_burst;
  logic              owner_valid;
  logic              owner_last;
  logic              beat;
  logic              release_burst;

  fifo_write_arbiter_rr_pick #(
    .N (N_REQ),
    .W (GID_W)
  ) u_rr_pick (
    .req      (bus.req_valid),
    .last_ptr (rr_ptr),
    .winner   (winner),
    .any      (any_req)
  );

  assign in_burst      = (state == ST_BURST);
  assign owner_valid   = bus.req_valid[grant_id_q];
  assign owner_last    = bus.req_last[grant_id_q];
  assign beat          = in_burst && owner_valid && !bus.fifo_full;
  // A full FIFO blocks the beat, so last under full neither transfers nor releases.
  assign release_burst = beat && (owner_last || (beat_cnt == BEAT_LAST));

  always_comb begin
    bus.req_ready = '0;
    if (in_burst) bus.req_ready[grant_id_q] = !bus.fifo_full;
  end

  assign bus.fifo_we     = beat;
  assign bus.fifo_din    = bus.req_data[int'(grant_id_q)*WIDTH +: WIDTH];
  assign bus.grant_valid = in_burst;
  assign bus.grant_id    = grant_id_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      grant_id_q <= '0;
      rr_ptr     <= PTR_INIT;
      beat_cnt   <= '0;
    end else if (state == ST_IDLE) begin
      if (any_req) begin
        state      <= ST_BURST;
        grant_id_q <= winner;
        rr_ptr     <= winner;
        beat_cnt   <= '0;
      end
    end else if (beat) begin
      if (release_burst) begin
        state    <= ST_IDLE;
        beat_cnt <= '0;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

`ifdef FIFO_WRITE_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      beat_count  <= '0;
      stall_count <= '0;
    end else begin
      if (beat)
        beat_count[int'(grant_id_q)*32 +: 32] <= beat_count[int'(grant_id_q)*32 +: 32] + 32'd1;
      if (in_burst && owner_valid && bus.fifo_full)
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed scenarios plus randomized producer queues
// checked against a burst-level round-robin model. Stats checks run when FIFO_WRITE_ARBITER_STATS_EN is defined.
module tb_fifo_write_arbiter;
  import fifo_write_arbiter_pkg::*;

  localparam int W    = 256;
  localparam int N    = 4;
  localparam int BMAX = 4;
  localparam int GW   = clog2(N);
  localparam int MAXB = 16;
  localparam int MAXS = N * MAXB;
  localparam int MAXC = 600;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.WIDTH(W), .N_REQ(N)) bus ();

`ifdef FIFO_WRITE_ARBITER_STATS_EN
  logic [N*32-1:0] beat_count;
  logic [31:0]     stall_count;
`endif

  fifo_write_arbiter #(.WIDTH(W), .N_REQ(N), .BURST_MAX(BMAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FIFO_WRITE_ARBITER_STATS_EN
    ,
    .beat_count  (beat_count),
    .stall_count (stall_count)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // producer queues, expected FIFO stream, scripted full pattern
  logic [W-1:0] qd [N][MAXB];
  logic         ql [N][MAXB];
  int           qlen [N];
  int           qhead [N];
  int           start_at [N];
  logic [W-1:0] ed [MAXS];
  int           eid [MAXS];
  int           elen;
  logic         full_script [MAXC];

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int j = 0; j < W/32; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive_idle();
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.fifo_full = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin
      qlen[i] = 0; qhead[i] = 0; start_at[i] = 0;
    end
    elen = 0;
    for (int c = 0; c < MAXC; c++) full_script[c] = 1'b0;
  endtask

  task automatic push(input int i, input logic [W-1:0] d, input logic l);
    qd[i][qlen[i]] = d;
    ql[i][qlen[i]] = l;
    qlen[i]++;
  endtask

  task automatic expect_all(input int i);
    for (int k = 0; k < qlen[i]; k++) begin
      ed[elen] = qd[i][k]; eid[elen] = i; elen++;
    end
  endtask

  // Burst-level model: next nonempty requester after the previous winner takes
  // beats until its last item or BMAX beats, whichever first.
  task automatic build_model();
    int h [N];
    int ptr, w, beats;
    logic l;
    for (int i = 0; i < N; i++) h[i] = 0;
    ptr = N - 1;
    elen = 0;
    forever begin
      w = -1;
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (ptr + k) % N;
        if (w < 0 && h[idx] < qlen[idx]) w = idx;
      end
      if (w < 0) break;
      ptr = w;
      beats = 0;
      do begin
        ed[elen] = qd[w][h[w]]; eid[elen] = w; elen++;
        l = ql[w][h[w]];
        h[w]++;
        beats++;
      end while (!l && beats < BMAX && h[w] < qlen[w]);
    end
  endtask

  // Well-behaved producers: present queue heads, pop on valid && ready.
  task automatic run_stream(input int max_cycles, input bit rnd_full);
    int eptr;
    logic [N-1:0] fired;
    logic [N-1:0] exp_rdy;
    logic exp_we;
    eptr = 0;
    for (int c = 0; c < max_cycles; c++) begin
      for (int i = 0; i < N; i++) begin
        if (c >= start_at[i] && qhead[i] < qlen[i]) begin
          bus.req_valid[i]         = 1'b1;
          bus.req_data[i*W +: W]   = qd[i][qhead[i]];
          bus.req_last[i]          = ql[i][qhead[i]];
        end else begin
          bus.req_valid[i]         = 1'b0;
          bus.req_data[i*W +: W]   = '0;
          bus.req_last[i]          = 1'b0;
        end
      end
      bus.fifo_full = rnd_full ? ($urandom_range(0, 3) == 0) : full_script[c];
      @(negedge clk);
      exp_rdy = '0;
      if (bus.grant_valid === 1'b1 && !bus.fifo_full) exp_rdy[bus.grant_id] = 1'b1;
      n_vec++;
      if (bus.req_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL ready c=%0d got=%b want=%b", c, bus.req_ready, exp_rdy);
      end
      fired  = bus.req_valid & bus.req_ready;
      exp_we = |fired;
      n_vec++;
      if (bus.fifo_we !== exp_we) begin
        n_err++;
        $display("FAIL fifo_we c=%0d got=%b want=%b", c, bus.fifo_we, exp_we);
      end
      if (bus.fifo_we === 1'b1) begin
        n_vec++;
        if (eptr >= elen) begin
          n_err++;
          $display("FAIL extra_beat c=%0d grant_id=%0d", c, bus.grant_id);
        end else if (bus.grant_id !== GW'(eid[eptr]) || bus.fifo_din !== ed[eptr]) begin
          n_err++;
          $display("FAIL stream beat=%0d got id=%0d din=%h want id=%0d din=%h",
                   eptr, bus.grant_id, bus.fifo_din[63:0], eid[eptr], ed[eptr][63:0]);
        end
        eptr++;
      end
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) if (fired[i]) qhead[i]++;
      if (eptr >= elen) break;
    end
    n_vec++;
    if (eptr != elen) begin
      n_err++;
      $display("FAIL stream_timeout got beats=%0d want=%0d", eptr, elen);
    end
    drive_idle();
    @(negedge clk);
    n_vec++;
    if (bus.grant_valid !== 1'b0) begin
      n_err++;
      $display("FAIL release grant_valid got=%b want=0", bus.grant_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_idle();
    bus.req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_vec++;
    if (bus.grant_valid !== 1'b0 || bus.grant_id !== '0 || bus.req_ready !== '0 || bus.fifo_we !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got gv=%b id=%0d rdy=%b we=%b want 0/0/0000/0",
               bus.grant_valid, bus.grant_id, bus.req_ready, bus.fifo_we);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_burst();
    logic [W-1:0] d [2];
    int pulses;
    d[0] = rand_word();
    d[1] = rand_word();
    pulses = 0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (pulses < 2) begin
        bus.req_valid         = 4'b0001;
        bus.req_data[0 +: W]  = d[pulses];
        bus.req_last          = (pulses == 1) ? 4'b0001 : 4'b0000;
      end else begin
        drive_idle();
      end
      @(negedge clk);
      if (c == 1) begin
        n_vec++;
        if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd0) begin
          n_err++;
          $display("FAIL single_grant got gv=%b id=%0d want 1/0", bus.grant_valid, bus.grant_id);
        end
      end
      if (bus.fifo_we === 1'b1) begin
        n_vec++;
        if (pulses >= 2) begin
          n_err++;
          $display("FAIL single_extra_pulse c=%0d", c);
        end else if (bus.fifo_din !== d[pulses]) begin
          n_err++;
          $display("FAIL single_data got=%h want=%h", bus.fifo_din[63:0], d[pulses][63:0]);
        end
        pulses++;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_vec++;
    if (pulses != 2 || bus.grant_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_count got pulses=%0d gv=%b want 2/0", pulses, bus.grant_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rr_all();
    logic [W-1:0] pat [N];
    int gid;
    logic exp_we;
    do_reset();
    for (int i = 0; i < N; i++) begin
      pat[i] = rand_word();
      bus.req_data[i*W +: W] = pat[i];
    end
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b0000;
    // cycle 0 arbitrates; then every 5 cycles: 4 beats, 1 idle
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      exp_we = (c % 5) != 0;
      gid    = (c / 5) % N;
      n_vec++;
      if (bus.fifo_we !== exp_we) begin
        n_err++;
        $display("FAIL rr_we c=%0d got=%b want=%b", c, bus.fifo_we, exp_we);
      end else if (exp_we && (bus.grant_id !== GW'(gid) || bus.fifo_din !== pat[gid])) begin
        n_err++;
        $display("FAIL rr_grant c=%0d got id=%0d want id=%0d", c, bus.grant_id, gid);
      end
      @(posedge clk); #1;
    end
    drive_idle();
  endtask

  task automatic test_full_stall();
    clear_queues();
    for (int k = 0; k < 6; k++) push(2, rand_word(), k == 5);
    for (int c = 3; c <= 5; c++) full_script[c] = 1'b1;
    build_model();
    do_reset();
    run_stream(60, 1'b0);
    n_vec++;
    if (qhead[2] != 6) begin
      n_err++;
      $display("FAIL stall_consumed got=%0d want=6", qhead[2]);
    end
  endtask

  task automatic test_skip_idle();
    clear_queues();
    for (int k = 0; k < 3; k++) push(1, rand_word(), k == 2);
    push(3, rand_word(), 1'b1);
    push(0, rand_word(), 1'b1);
    start_at[0] = 2;
    start_at[3] = 2;
    expect_all(1);
    expect_all(3);
    expect_all(0);
    do_reset();
    run_stream(40, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req_valid = 4'b0100;
    bus.req_data[2*W +: W] = rand_word();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.fifo_we !== 1'b1 || bus.grant_id !== 2'd2) begin
      n_err++;
      $display("FAIL midreset_before got we=%b id=%0d want 1/2", bus.fifo_we, bus.grant_id);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (bus.grant_valid !== 1'b0 || bus.req_ready !== '0 || bus.grant_id !== '0 || bus.fifo_we !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_after got gv=%b rdy=%b id=%0d we=%b want 0/0000/0/0",
               bus.grant_valid, bus.req_ready, bus.grant_id, bus.fifo_we);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    bus.req_valid = 4'b1010;
    bus.req_data[1*W +: W] = rand_word();
    bus.req_data[3*W +: W] = rand_word();
    @(negedge clk);
    n_vec++;
    if (bus.grant_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_arb_latency got gv=%b want 0", bus.grant_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd1) begin
      n_err++;
      $display("FAIL midreset_regrant got gv=%b id=%0d want 1/1", bus.grant_valid, bus.grant_id);
    end
    @(posedge clk); #1;
    drive_idle();
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 8; r++) begin
      clear_queues();
      for (int i = 0; i < N; i++) begin
        n = $urandom_range(0, 7);
        for (int k = 0; k < n; k++)
          push(i, rand_word(), (k == n - 1) ? 1'b1 : ($urandom_range(0, 3) == 0));
      end
      build_model();
      do_reset();
      run_stream(400, 1'b1);
    end
  endtask

`ifdef FIFO_WRITE_ARBITER_STATS_EN
  task automatic test_stats();
    logic [31:0] want;
    clear_queues();
    for (int k = 0; k < 10; k++) push(1, rand_word(), k == 9);
    full_script[2] = 1'b1;
    full_script[3] = 1'b1;
    build_model();
    do_reset();
    run_stream(80, 1'b0);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      want = (i == 1) ? 32'd10 : 32'd0;
      n_vec++;
      if (beat_count[i*32 +: 32] !== want) begin
        n_err++;
        $display("FAIL beat_count[%0d] got=%0d want=%0d", i, beat_count[i*32 +: 32], want);
      end
    end
    n_vec++;
    if (stall_count !== 32'd2) begin
      n_err++;
      $display("FAIL stall_count got=%0d want=2", stall_count);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    reset = 1'b0;
    drive_idle();
    test_reset();
    test_single_burst();
    test_rr_all();
    test_full_stall();
    test_skip_idle();
    test_reset_mid();
    test_random();
`ifdef FIFO_WRITE_ARBITER_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port of one simple_fifo instance between N_REQ independent producers.
- Uses round-robin arbitration with burst locking: once granted, a producer owns the port until it signals last or hits BURST_MAX beats.
- Sits directly in front of simple_fifo; drives its we/din and obeys its full.

Parameters:
- WIDTH, 256, data width of each requester and of the FIFO port.
- N_REQ, 4, number of requesters (2..8).
- BURST_MAX, 4, max beats per grant before forced release (1..255).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous reset, active-low (0 = reset), sampled on rising clk.
- req_valid  in  N_REQ  per-requester data valid.
- req_data  in  N_REQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- req_last  in  N_REQ  final beat of requester's burst, qualified by valid.
- req_ready  out  N_REQ  per-requester accept; transfer when valid && ready.
- fifo_we  out  1  to simple_fifo we.
- fifo_din  out  WIDTH  to simple_fifo din.
- fifo_full  in  1  from simple_fifo full.
- grant_valid  out  1  a requester currently owns the port.
- grant_id  out  clog2(N_REQ)  index of current owner.

Behaviour:
- FSM states: IDLE, BURST.
- Reset (reset==0 at clk edge): state=IDLE, grant_valid=0, grant_id=0, rr pointer=N_REQ-1 (so requester 0 wins first), beat counter=0, req_ready=0, fifo_we=0.
- IDLE: if any req_valid, select first asserted index searching upward from rr_ptr+1 modulo N_REQ.
  - Next cycle: state=BURST, grant_id=winner, grant_valid=1, beat_cnt=0, rr_ptr=winner.
  - No data moves in IDLE, giving 1 cycle arbitration latency.
- BURST, combinational outputs:
  - req_ready[grant_id] = !fifo_full; all other req_ready bits = 0.
  - fifo_we = req_valid[grant_id] && !fifo_full.
  - fifo_din = req_data[grant_id] (don't-care when fifo_we=0).
- BURST, per beat (fifo_we=1): beat_cnt increments.
- BURST, release: if req_last[grant_id] or beat_cnt==BURST_MAX-1 on that beat, next state=IDLE, grant_valid=0.
  - grant_id holds its last value.
- Owner dropping valid mid-burst: grant is held, no timeout; the bubble is legal.
- fifo_full mid-burst: stall with no beat counted and no loss; the owner must hold data/last stable.
- Full and last on the same cycle: no transfer, no release.
- beat_cnt width: clog2(BURST_MAX+1); it never exceeds BURST_MAX-1.
- Reset asserted mid-burst: immediate return to reset values at that edge. A partial burst in the FIFO is not rolled back.
- Fairness: a requester continuously valid is granted within N_REQ-1 other bursts.

Optional Feature:
- Macro: FIFO_WRITE_ARBITER_STATS_EN.
- When defined:
  - Adds output beat_count, N_REQ*32 bits: per-requester 32-bit beat counters that wrap at 2^32, cleared by reset.
  - Adds output stall_count, 32 bits: increments each BURST cycle with req_valid[grant_id] && fifo_full.
- When undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package fifo_write_arbiter_pkg:
  - state enum {IDLE, BURST};
  - function clog2;
  - localparam widths for grant_id and beat_cnt.
- Sub-module rr_pick, combinational, parameter N:
  - inputs: request vector, last-pointer;
  - outputs: winner index and any flag.
- Datapath mux and FSM stay in the top.

Test Plan:
- Reset release with req_valid=4'b0001, last on beat 2 -> grant_id=0 one cycle after request; exactly 2 fifo_we pulses; return to IDLE.
- All four valid continuously, BURST_MAX=4, no last -> grants 0,1,2,3,0; each burst exactly 4 beats; one idle cycle between bursts.
- fifo_full held high 3 cycles mid-burst on requester 2 -> req_ready[2]=0 and fifo_we=0 for those 3 cycles; beat_cnt frozen; data order intact at FIFO output.
- After grant to 1, requests 3 and 0 pending -> next grant 3 (pointer 1+1=2 skipped as idle), then 0.
- Reset driven low on beat 2 of a burst -> next edge: grant_valid=0, all req_ready=0, grant_id=0; first post-reset grant goes to the lowest valid index.
- FIFO_WRITE_ARBITER_STATS_EN defined, 10 beats from requester 1 with 2 full cycles -> beat_count[1]=10, stall_count=2, others 0.
